// File: rtl/alu_bcd_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_bcd_branch_unit : 1-cycle ALU, binary->BCD converter, branch target.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module alu_bcd_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result1,
  output logic [31:0] result2,
  output logic        eq,
  output logic        greater_eq,
  output logic        lesser,
  input  logic [31:0] bin,
  output logic [31:0] bcd,
  input  logic [11:0] imm_b,
  input  logic [31:0] cur_pc,
  output logic [31:0] next_pc
);

  localparam logic [3:0] c_OP_SLL  = 4'd0;
  localparam logic [3:0] c_OP_SRA  = 4'd1;
  localparam logic [3:0] c_OP_SRL  = 4'd2;
  localparam logic [3:0] c_OP_MUL  = 4'd3;
  localparam logic [3:0] c_OP_DIV  = 4'd4;
  localparam logic [3:0] c_OP_ADD  = 4'd5;
  localparam logic [3:0] c_OP_SUB  = 4'd6;
  localparam logic [3:0] c_OP_AND  = 4'd7;
  localparam logic [3:0] c_OP_OR   = 4'd8;
  localparam logic [3:0] c_OP_XOR  = 4'd9;
  localparam logic [3:0] c_OP_NOR  = 4'd10;
  localparam logic [3:0] c_OP_SLT  = 4'd11;
  localparam logic [3:0] c_OP_SLTU = 4'd12;

  logic [31:0] w_res1;
  logic [31:0] w_res2;
  logic [63:0] w_prod;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [32:0] w_div_sh;
  logic        w_eq;
  logic        w_ge;
  logic        w_lt;
  logic [31:0] w_bcd;
  logic [31:0] w_next_pc;

  logic [31:0] r_result1;
  logic [31:0] r_result2;
  logic        r_eq;
  logic        r_ge;
  logic        r_lt;
  logic [31:0] r_bcd;
  logic [31:0] r_next_pc;

  assign w_eq   = (a == b);
  assign w_ge   = ($signed(a) >= $signed(b));
  assign w_lt   = (a < b);
  assign w_prod = {32'h0, a} * {32'h0, b};

  // Restoring divider; a zero divisor falls out as all-ones quotient, remainder a.
  always_comb begin
    w_div_q  = '0;
    w_div_r  = '0;
    w_div_sh = '0;
    for (int i = 31; i >= 0; i--) begin
      w_div_sh = {w_div_r, a[i]};
      if (w_div_sh >= {1'b0, b}) begin
        w_div_r    = 32'(w_div_sh - {1'b0, b});
        w_div_q[i] = 1'b1;
      end else begin
        w_div_r = w_div_sh[31:0];
      end
    end
  end

  always_comb begin
    w_res1 = '0;
    w_res2 = '0;
    case (op)
      c_OP_SLL:  w_res1 = a << b[4:0];
      c_OP_SRA:  w_res1 = $signed(a) >>> b[4:0];
      c_OP_SRL:  w_res1 = a >> b[4:0];
      c_OP_MUL: begin
        w_res1 = w_prod[31:0];
        w_res2 = w_prod[63:32];
      end
      c_OP_DIV: begin
        w_res1 = (b == 32'h0) ? 32'hFFFF_FFFF : w_div_q;
        w_res2 = (b == 32'h0) ? a : w_div_r;
      end
      c_OP_ADD:  w_res1 = a + b;
      c_OP_SUB:  w_res1 = a - b;
      c_OP_AND:  w_res1 = a & b;
      c_OP_OR:   w_res1 = a | b;
      c_OP_XOR:  w_res1 = a ^ b;
      c_OP_NOR:  w_res1 = ~(a | b);
      c_OP_SLT:  w_res1 = {31'h0, ~w_ge};
      c_OP_SLTU: w_res1 = {31'h0, w_lt};
      default: begin
        w_res1 = '0;
        w_res2 = '0;
      end
    endcase
  end

  // Double-dabble on 8 digits only: carries out of the top digit are the
  // multiples of 10^8, so dropping them yields bin mod 10^8 directly.
  always_comb begin
    w_bcd = '0;
    for (int i = 31; i >= 0; i--) begin
      for (int d = 0; d < 8; d++) begin
        if (w_bcd[4*d +: 4] >= 4'd5) begin
          w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
        end
      end
      w_bcd = {w_bcd[30:0], bin[i]};
    end
  end

  assign w_next_pc = cur_pc + {{19{imm_b[11]}}, imm_b, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result1 <= '0;
      r_result2 <= '0;
      r_eq      <= 1'b0;
      r_ge      <= 1'b0;
      r_lt      <= 1'b0;
      r_bcd     <= '0;
      r_next_pc <= '0;
    end else begin
      r_result1 <= w_res1;
      r_result2 <= w_res2;
      r_eq      <= w_eq;
      r_ge      <= w_ge;
      r_lt      <= w_lt;
      r_bcd     <= w_bcd;
      r_next_pc <= w_next_pc;
    end
  end

  assign result1    = r_result1;
  assign result2    = r_result2;
  assign eq         = r_eq;
  assign greater_eq = r_ge;
  assign lesser     = r_lt;
  assign bcd        = r_bcd;
  assign next_pc    = r_next_pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_bcd_branch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_alu_bcd_branch_unit : scoreboard bench with a behavioural reference.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_alu_bcd_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b, bin, cur_pc;
  logic [3:0]  op;
  logic [11:0] imm_b;
  logic [31:0] result1, result2, bcd, next_pc;
  logic        eq, greater_eq, lesser;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] bcd;
    logic [31:0] pc;
    logic        eq;
    logic        ge;
    logic        lt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_bcd_branch_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
    .result1(result1), .result2(result2),
    .eq(eq), .greater_eq(greater_eq), .lesser(lesser),
    .bin(bin), .bcd(bcd), .imm_b(imm_b), .cur_pc(cur_pc), .next_pc(next_pc)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] fa, input logic [31:0] fb,
                                 input logic [3:0] fop, input logic [31:0] fbin,
                                 input logic [11:0] fimm, input logic [31:0] fpc);
    exp_t        e;
    logic [63:0] p;
    logic [31:0] v;
    int          off;
    e = '0;
    case (fop)
      4'd0:  e.r1 = fa << fb[4:0];
      4'd1:  e.r1 = $signed(fa) >>> fb[4:0];
      4'd2:  e.r1 = fa >> fb[4:0];
      4'd3: begin
        p = 64'(fa) * 64'(fb);
        e.r1 = p[31:0];
        e.r2 = p[63:32];
      end
      4'd4: begin
        if (fb == 0) begin
          e.r1 = 32'hFFFF_FFFF;
          e.r2 = fa;
        end else begin
          e.r1 = fa / fb;
          e.r2 = fa % fb;
        end
      end
      4'd5:  e.r1 = fa + fb;
      4'd6:  e.r1 = fa - fb;
      4'd7:  e.r1 = fa & fb;
      4'd8:  e.r1 = fa | fb;
      4'd9:  e.r1 = fa ^ fb;
      4'd10: e.r1 = ~(fa | fb);
      4'd11: e.r1 = ($signed(fa) < $signed(fb)) ? 32'd1 : 32'd0;
      4'd12: e.r1 = (fa < fb) ? 32'd1 : 32'd0;
      default: e.r1 = 32'd0;
    endcase
    e.eq = (fa == fb);
    e.ge = ($signed(fa) >= $signed(fb));
    e.lt = (fa < fb);
    v = fbin % 32'd100000000;
    for (int d = 0; d < 8; d++) begin
      e.bcd[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
    off  = $signed({fimm, 1'b0});
    e.pc = fpc + 32'(off);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".result1"}, result1, 32'h0);
    check({tag, ".result2"}, result2, 32'h0);
    check({tag, ".bcd"}, bcd, 32'h0);
    check({tag, ".next_pc"}, next_pc, 32'h0);
    check({tag, ".flags"}, {29'h0, eq, greater_eq, lesser}, 32'h0);
  endtask

  task automatic drive(input logic [31:0] da, input logic [31:0] db, input logic [3:0] dop,
                       input logic [31:0] dbin, input logic [11:0] dimm, input logic [31:0] dpc);
    @(negedge clk);
    a = da; b = db; op = dop; bin = dbin; imm_b = dimm; cur_pc = dpc;
    sb.push_back(model(da, db, dop, dbin, dimm, dpc));
  endtask

  // Monitor: every output sample after an edge retires one expected entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        check("result1", result1, e.r1);
        check("result2", result2, e.r2);
        check("bcd", bcd, e.bcd);
        check("next_pc", next_pc, e.pc);
        check("flags{eq,ge,lt}", {29'h0, eq, greater_eq, lesser}, {29'h0, e.eq, e.ge, e.lt});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb, rbin;
    rst = 1'b1;
    a = 32'h1234_5678; b = 32'h9; op = 4'd5; bin = 32'd987; imm_b = 12'h010; cur_pc = 32'h400;
    #2;
    check_zero("reset_init");
    @(posedge clk); #1;
    check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(a, b, op, bin, imm_b, cur_pc));

    // Directed cases
    drive(32'hFFFF_FFFF, 32'd2, 4'd3, 32'd12345678, 12'hFFE, 32'h100);
    drive(32'd100, 32'd7, 4'd4, 32'd0, 12'h004, 32'h100);
    drive(32'd100, 32'd0, 4'd4, 32'hFFFF_FFFF, 12'h800, 32'h0);
    drive(32'h8000_0000, 32'd1, 4'd1, 32'd99999999, 12'h7FF, 32'hFFFF_FFF0);
    drive(32'h8000_0000, 32'd1, 4'd11, 32'd100000000, 12'h000, 32'h10);
    drive(32'h8000_0000, 32'd1, 4'd12, 32'd5, 12'h001, 32'h20);
    for (int o = 13; o < 16; o++) drive(32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'(o), 32'd42, 12'h3, 32'h0);

    // Mid-stream reset: outputs clear between edges and stale results never reappear
    drive(32'hFFFF_FFFF, 32'd3, 4'd3, 32'd12345678, 12'h004, 32'h100);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_zero("reset_async");
    @(negedge clk);
    a = 32'd50; b = 32'd50; op = 4'd6; bin = 32'd7; imm_b = 12'hFFC; cur_pc = 32'h8;
    @(posedge clk); #1;
    check_zero("reset_held");
    @(negedge clk);
    rst = 1'b0;
    sb.push_back(model(a, b, op, bin, imm_b, cur_pc));

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'h0;
        1: rb = ra;
        2: rb = $urandom_range(0, 40);
        default: rb = $urandom;
      endcase
      rbin = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 99999999) : $urandom;
      drive(ra, rb, 4'($urandom_range(0, 15)), rbin, 12'($urandom), $urandom);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_bcd_branch_unit.md
ALU_BCD_BRANCH_UNIT -- requirements
Module: alu_bcd_branch_unit

Interface
REQ-001 The module SHALL have no parameters; all datapaths are fixed at the widths below.
REQ-002 clk  input  1  single clock; all outputs are registered on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 a  input  32  ALU operand A.
REQ-005 b  input  32  ALU operand B; b[4:0] is the shift amount for shift ops.
REQ-006 op  input  4  ALU operation select.
REQ-007 result1  output  32  primary ALU result.
REQ-008 result2  output  32  secondary ALU result (MUL high word / DIV remainder, else 0).
REQ-009 eq  output  1  a == b.
REQ-010 greater_eq  output  1  signed a >= b.
REQ-011 lesser  output  1  unsigned a < b.
REQ-012 bin  input  32  unsigned binary value to convert.
REQ-013 bcd  output  32  8 packed BCD digits; bcd[31:28] most significant.
REQ-014 imm_b  input  12  B-type immediate {instr[31],instr[7],instr[30:25],instr[11:8]}.
REQ-015 cur_pc  input  32  PC of the branch instruction.
REQ-016 next_pc  output  32  branch target.

Function
REQ-017 All outputs SHALL be computed combinationally from the current inputs and registered; latency is exactly 1 clk cycle, with a new result every cycle.
REQ-018 op encoding SHALL be:
- 0 SLL: a << b[4:0]
- 1 SRA: arithmetic a >> b[4:0]
- 2 SRL: logical a >> b[4:0]
- 3 MUL: unsigned 64-bit a*b; result1 = low 32, result2 = high 32
- 4 DIV: unsigned; result1 = a/b, result2 = a%b
- 5 ADD, 6 SUB: modulo 2^32, no overflow flag
- 7 AND, 8 OR, 9 XOR, 10 NOR
- 11 SLT: signed a<b ? 1 : 0
- 12 SLTU: unsigned a<b ? 1 : 0
REQ-019 DIV with b == 0 SHALL give result1 = 32'hFFFF_FFFF and result2 = a.
REQ-020 op 13..15 SHALL give result1 = 0 and result2 = 0.
REQ-021 result2 SHALL be 0 for every op other than 3 and 4.
REQ-022 eq, greater_eq and lesser SHALL be computed from a and b regardless of op.
REQ-023 bcd SHALL be the decimal representation of (bin mod 100,000,000), one BCD nibble per digit with leading zeros; values >= 10^8 keep only the low 8 decimal digits.
REQ-024 next_pc SHALL be cur_pc + sign_extend({imm_b,1'b0}) to 32 bits, i.e. an offset range of -4096..+4094, with 32-bit wrap-around.
REQ-025 The ALU, BCD and branch paths SHALL be mutually independent; a change on one input group SHALL not affect the other paths' outputs.

Reset
REQ-026 While rst = 1, all outputs SHALL be 0 (result1, result2, bcd, next_pc = 32'h0; eq, greater_eq, lesser = 0), asynchronously and independent of clk.
REQ-027 After rst falls, the first rising clk edge SHALL load valid results from the then-current inputs.
REQ-028 If rst is asserted mid-stream, outputs SHALL clear immediately; no result computed before reset SHALL appear afterwards.

Verification
REQ-029 MUL: a=32'hFFFF_FFFF, b=2, op=3 -> one cycle later result1=32'hFFFF_FFFE, result2=32'h1.
REQ-030 DIV: a=100, b=7, op=4 -> result1=14, result2=2; then b=0 -> result1=32'hFFFF_FFFF, result2=100.
REQ-031 Flags/shift: a=32'h8000_0000, b=1, op=1 -> result1=32'hC000_0000; eq=0, greater_eq=0, lesser=0; op=11 -> result1=1; op=12 -> result1=0.
REQ-032 BCD: bin=12345678 -> bcd=32'h1234_5678; bin=0 -> 0; bin=32'hFFFF_FFFF (4294967295) -> bcd=32'h9496_7295.
REQ-033 Branch: cur_pc=32'h100, imm_b=12'hFFE (offset -4) -> next_pc=32'hFC; imm_b=12'h004 -> next_pc=32'h108; cur_pc=0, imm_b=12'h800 -> next_pc=32'hFFFF_F000.
REQ-034 Reset: with outputs non-zero, assert rst between clk edges -> all outputs 0 immediately and held at 0 while rst=1; release -> results valid after the next edge.
